// File: rtl/fft16_bitrev_loader_if.sv
// Stream bundle for the bit-reversing loader: natural-order sample input with
// valid/ready, and the bit-reversed serial burst that feeds the FFT top.
interface fft16_bitrev_loader_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_start;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_start, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_start, out_valid, out_data
  );
endinterface

// File: rtl/fft16_bitrev_loader.sv
// Ping-pong frame buffer: collects N natural-order samples per bank and replays
// each full bank as a gapless N-cycle burst in bit-reversed order.
module fft16_bitrev_loader #(
  parameter int DATA_W = 64,
  parameter int N      = 16,
  parameter int LOG2N  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  fft16_bitrev_loader_if.slave s_if,
  output logic [7:0]           o_frame_cnt
);

  typedef enum logic {ST_IDLE, ST_STREAM} rd_state_t;

  logic [DATA_W-1:0] r_mem [0:2*N-1];

  logic [LOG2N-1:0]  r_wr_cnt;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [1:0]        r_bank_full;
  rd_state_t         r_state;
  logic [LOG2N-1:0]  r_rd_cnt;
  logic              r_out_start;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [7:0]        r_frame_cnt;

  logic              w_in_ready;
  logic              w_xfer;
  logic              w_wr_last;
  logic              w_rd_go;
  logic              w_rd_last;
  logic [LOG2N-1:0]  w_rd_idx;
  logic [LOG2N-1:0]  w_rd_rev;
  logic [1:0]        w_set;
  logic [1:0]        w_clr;

  assign w_in_ready = !r_bank_full[r_wr_bank];
  assign w_xfer     = s_if.in_valid && w_in_ready && !i_flush;
  assign w_wr_last  = w_xfer && (r_wr_cnt == LOG2N'(N-1));

  // In IDLE the first burst sample (index 0) is fetched on the same edge the burst starts.
  assign w_rd_idx  = (r_state == ST_IDLE) ? '0 : r_rd_cnt;
  assign w_rd_go   = (r_state == ST_STREAM) || r_bank_full[r_rd_bank];
  assign w_rd_last = (r_state == ST_STREAM) && (r_rd_cnt == LOG2N'(N-1));

  genvar gi;
  generate
    for (gi = 0; gi < LOG2N; gi++) begin : g_bitrev
      assign w_rd_rev[gi] = w_rd_idx[LOG2N-1-gi];
    end
    for (gi = 0; gi < 2; gi++) begin : g_bank_flags
      assign w_set[gi] = w_wr_last && (r_wr_bank == 1'(gi));
      assign w_clr[gi] = w_rd_last && (r_rd_bank == 1'(gi));
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (w_xfer) begin
      r_mem[{r_wr_bank, r_wr_cnt}] <= s_if.in_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (i_flush) begin
      r_wr_cnt <= '0;
    end else if (w_xfer) begin
      r_wr_cnt <= r_wr_cnt + LOG2N'(1);
      if (w_wr_last) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // Fill and drain always target different banks, so set and clear never collide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bank_full <= 2'b00;
    end else begin
      r_bank_full <= (r_bank_full | w_set) & ~w_clr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_rd_cnt    <= '0;
      r_rd_bank   <= 1'b0;
      r_out_start <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_frame_cnt <= 8'd0;
    end else if (w_rd_go) begin
      r_out_data  <= r_mem[{r_rd_bank, w_rd_rev}];
      r_out_valid <= 1'b1;
      r_out_start <= (r_state == ST_IDLE);
      r_rd_cnt    <= w_rd_idx + LOG2N'(1);
      // Dropping back to IDLE after the last index lets a full partner bank start gaplessly.
      if (w_rd_last) begin
        r_state     <= ST_IDLE;
        r_rd_bank   <= ~r_rd_bank;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else begin
        r_state <= ST_STREAM;
      end
    end else begin
      r_out_valid <= 1'b0;
      r_out_start <= 1'b0;
    end
  end

  assign s_if.in_ready  = w_in_ready;
  assign s_if.out_start = r_out_start;
  assign s_if.out_valid = r_out_valid;
  assign s_if.out_data  = r_out_data;
  assign o_frame_cnt    = r_frame_cnt;

endmodule

// File: doc/fft16_bitrev_loader.md
Name: fft16_bitrev_loader

Overview:
- Input stage placed directly upstream of the 16-point FFT top.
- Accepts complex-free real samples in natural time order over a valid/ready stream and buffers them in a ping-pong RAM (2 banks × 16 words).
- Replays each completed frame as a contiguous 16-cycle serial burst in bit-reversed order, with a one-cycle start strobe, so the FFT top's start/in ports can be driven directly.
- Removes all host-side bit-reversal of FFT inputs.

Parameters:
- DATA_W, 64, sample width in bits; matches the FFT top serial input.
- N, 16, frame length in samples; fixed at 16 for this revision.
- LOG2N, 4, address width; must equal log2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; discards the partially written frame.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  loader can accept a sample.
- in_data  input  DATA_W  sample, natural order, signed.
- out_start  output  1  high for the first sample of each burst; drives FFT start.
- out_valid  output  1  high on every burst sample.
- out_data  output  DATA_W  bit-reversed-order sample; drives FFT in.
- frame_cnt  output  8  completed bursts, wraps 255->0.

Behaviour:
- Reset (rst=0, async): wr_cnt=0, wr_bank=0, rd_bank=0, bank_full=2'b00, read FSM=IDLE, rd_cnt=0. Outputs out_start=0, out_valid=0, out_data=0, frame_cnt=0. RAM contents are don't-care. Reset mid-burst aborts the burst immediately (out_valid low asynchronously) and drops both banks.
- in_ready = !bank_full[wr_bank] (combinational from flags).
- Write side: a transfer is in_valid && in_ready at a rising edge.
  - On a transfer: mem[wr_bank][wr_cnt] <= in_data, then wr_cnt++.
  - On the transfer with wr_cnt==15: set bank_full[wr_bank], wr_cnt=0, toggle wr_bank.
- flush=1: wr_cnt<=0 and the incoming sample is ignored that edge. Full banks and an active burst are unaffected. flush has priority over a simultaneous transfer.
- Read FSM:
  - IDLE: if bank_full[rd_bank], go to STREAM. That same edge registers mem[rd_bank][bitrev(0)], out_valid=1, out_start=1, rd_cnt=1.
  - STREAM: each edge registers mem[rd_bank][bitrev(rd_cnt)], out_valid=1, out_start=0, rd_cnt++.
  - On the edge that loads index 15: clear bank_full[rd_bank], toggle rd_bank, frame_cnt++.
  - After index 15, at the next edge: if the other bank is full, begin a new burst immediately (out_start=1, gapless). Otherwise go to IDLE, with out_valid=0 and out_data holding its last value.
- Bit reversal: bitrev({b3,b2,b1,b0}) = {b0,b1,b2,b3}. Burst order is x0,x8,x4,x12,x2,x10,x6,x14,x1,x9,x5,x13,x3,x11,x7,x15.
- Latency: the 16th sample is accepted at edge k; out_start is high in the cycle after edge k+1.
- Bursts are never interrupted. The downstream block has no backpressure.
- Simultaneous events: a write that fills one bank and a read that frees the other bank on the same edge both take effect. Sustained 1 sample/cycle input never deasserts in_ready.

Test Plan:
- Reset, then 16 consecutive samples 0..15 with in_valid held high. Required: out_start high exactly one cycle, 2 edges after the 16th transfer. out_data sequence is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. frame_cnt=1.
- Three back-to-back frames (samples 0..47) at 1/cycle. Required: in_ready never low. 48 contiguous out_valid cycles. out_start on burst cycles 0, 16 and 32. Third burst begins 32,40,36,...,47. frame_cnt=3.
- Frame 0..15 delivered with in_valid high every other cycle. Required: the burst is still 16 contiguous cycles with the same order as the first test, starting 2 edges after the last transfer.
- Write 5 samples, pulse flush with in_valid=1, then write 100..115. Required: burst is 100,108,104,...,115. The flushed-cycle sample is absent. frame_cnt=1.
- Assert rst=0 during burst cycle 7 for 2 cycles, then resend 0..15. Required: out_valid and out_data go to 0 immediately. frame_cnt=0 after reset. The post-reset burst is correct and frame_cnt=1.
- 256 frames. Required: frame_cnt wraps to 0 after the 256th burst.
